// File: rtl/pcpi_hub.sv
// PCPI hub: broadcasts core PCPI requests to NUM_CP coprocessors, locks onto the
// lowest-index claimant, returns its result and traps unclaimed or hung instructions.
module pcpi_hub #(
  parameter int NUM_CP   = 2,
  parameter int TIMEOUT  = 16,
  parameter int MAX_BUSY = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pcpi_valid,
  input  logic [31:0]          pcpi_insn,
  input  logic [31:0]          pcpi_rs1,
  input  logic [31:0]          pcpi_rs2,
  output logic                 pcpi_wr,
  output logic [31:0]          pcpi_rd,
  output logic                 pcpi_wait,
  output logic                 pcpi_ready,
  output logic [NUM_CP-1:0]    cp_valid,
  output logic [31:0]          cp_insn,
  output logic [31:0]          cp_rs1,
  output logic [31:0]          cp_rs2,
  input  logic [NUM_CP-1:0]    cp_wr,
  input  logic [32*NUM_CP-1:0] cp_rd,
  input  logic [NUM_CP-1:0]    cp_wait,
  input  logic [NUM_CP-1:0]    cp_ready,
  output logic                 trap
);

  localparam int OW = (NUM_CP > 1) ? $clog2(NUM_CP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLAIM, S_BUSY, S_DRAIN} state_t;

  state_t         r_state;
  logic [OW-1:0]  r_owner;
  logic [31:0]    r_cnt;
  logic           r_wr;
  logic           r_ready;
  logic           r_trap;
  logic [31:0]    r_rd;

  logic [NUM_CP-1:0] w_claim_vec;
  logic              w_claim;
  logic              w_found;
  logic [OW-1:0]     w_first;
  logic [OW-1:0]     w_sel;
  logic [31:0]       w_sel_rd;
  logic              w_sel_wr;
  logic              w_sel_ready;
  logic              w_sel_wait;

  assign cp_insn = pcpi_insn;
  assign cp_rs1  = pcpi_rs1;
  assign cp_rs2  = pcpi_rs2;

  assign w_claim_vec = cp_wait | cp_ready;
  assign w_claim     = |w_claim_vec;

  always_comb begin
    w_first = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NUM_CP; i++) begin
      if (w_claim_vec[i] && !w_found) begin
        w_first = OW'(i);
        w_found = 1'b1;
      end
    end
  end

  // During CLAIM the freshly arbitrated claimant is observed; afterwards only the latched owner.
  assign w_sel = (r_state == S_CLAIM) ? w_first : r_owner;

  always_comb begin
    w_sel_rd    = '0;
    w_sel_wr    = 1'b0;
    w_sel_ready = 1'b0;
    w_sel_wait  = 1'b0;
    for (int unsigned i = 0; i < NUM_CP; i++) begin
      if (OW'(i) == w_sel) begin
        w_sel_rd    = cp_rd[32*i +: 32];
        w_sel_wr    = cp_wr[i];
        w_sel_ready = cp_ready[i];
        w_sel_wait  = cp_wait[i];
      end
    end
  end

  always_comb begin
    cp_valid = '0;
    for (int unsigned i = 0; i < NUM_CP; i++) begin
      cp_valid[i] = pcpi_valid &&
                    (r_state == S_CLAIM || (r_state == S_BUSY && OW'(i) == r_owner));
    end
  end

  always_comb begin
    case (r_state)
      S_CLAIM: pcpi_wait = |(cp_wait & cp_valid);
      S_BUSY:  pcpi_wait = w_sel_wait;
      default: pcpi_wait = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_wr    <= 1'b0;
      r_ready <= 1'b0;
      r_trap  <= 1'b0;
      r_rd    <= '0;
    end else begin
      r_wr    <= 1'b0;
      r_ready <= 1'b0;
      r_trap  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pcpi_valid) begin
            r_state <= S_CLAIM;
            r_cnt   <= '0;
          end
        end
        S_CLAIM: begin
          if (!pcpi_valid) begin
            r_state <= S_IDLE;
          end else if (w_claim) begin
            r_owner <= w_first;
            if (w_sel_ready) begin
              r_rd    <= w_sel_rd;
              r_wr    <= w_sel_wr;
              r_ready <= 1'b1;
              r_state <= S_DRAIN;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= '0;
            end
          end else if (r_cnt == 32'(TIMEOUT - 1)) begin
            r_trap  <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_BUSY: begin
          if (!pcpi_valid) begin
            r_state <= S_IDLE;
          end else if (w_sel_ready) begin
            r_rd    <= w_sel_rd;
            r_wr    <= w_sel_wr;
            r_ready <= 1'b1;
            r_state <= S_DRAIN;
          end else if (r_cnt == 32'(MAX_BUSY - 1)) begin
            r_trap  <= 1'b1;
            r_state <= S_DRAIN;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_DRAIN: begin
          if (!pcpi_valid) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pcpi_wr    = r_wr;
  assign pcpi_rd    = r_rd;
  assign pcpi_ready = r_ready;
  assign trap       = r_trap;

endmodule

// File: tb/tb_pcpi_hub.sv
// Directed testbench for pcpi_hub with two coprocessors driven by hand;
// all expected values are hand-computed constants.
module tb_pcpi_hub;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, trap;
  logic [31:0] pcpi_rd;
  logic [1:0]  cp_valid;
  logic [31:0] cp_insn, cp_rs1, cp_rs2;
  logic [1:0]  cp_wr, cp_wait, cp_ready;
  logic [63:0] cp_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pcpi_hub #(.NUM_CP(2), .TIMEOUT(16), .MAX_BUSY(128)) dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .cp_valid(cp_valid), .cp_insn(cp_insn), .cp_rs1(cp_rs1), .cp_rs2(cp_rs2),
    .cp_wr(cp_wr), .cp_rd(cp_rd), .cp_wait(cp_wait), .cp_ready(cp_ready),
    .trap(trap)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cp_idle();
    cp_wr = '0; cp_wait = '0; cp_ready = '0; cp_rd = '0;
  endtask

  // Drop the request out of DRAIN and let the hub return to IDLE.
  task automatic release_req();
    pcpi_valid = 1'b0;
    cp_idle();
    tick();
  endtask

  initial begin
    reset = 1'b1; pcpi_valid = 1'b0;
    pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    cp_idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_ready", pcpi_ready, 0);
    check("rst_trap",  trap, 0);
    check("rst_wr",    pcpi_wr, 0);
    check("rst_rd",    pcpi_rd, 0);
    check("rst_cpv",   cp_valid, 0);
    check("rst_wait",  pcpi_wait, 0);

    // MUL to cp0: 34 waiting cycles, then ready with 0xF00
    pcpi_valid = 1'b1; pcpi_insn = 32'h02B50533; pcpi_rs1 = 32'h30; pcpi_rs2 = 32'h50;
    #1;
    check("mul_idle_cpv", cp_valid, 2'b00);
    tick();
    check("mul_claim_cpv", cp_valid, 2'b11);
    check("mul_insn_pass", cp_insn, 32'h02B50533);
    check("mul_rs2_pass",  cp_rs2, 32'h50);
    cp_wait = 2'b01;
    #1;
    check("mul_claim_wait", pcpi_wait, 1);
    tick();
    for (int i = 0; i < 33; i++) begin
      if (i == 0) check("mul_busy_cpv", cp_valid, 2'b01);
      check("mul_busy_noready", pcpi_ready, 0);
      tick();
    end
    cp_wait = 2'b00; cp_ready = 2'b01; cp_wr = 2'b01; cp_rd[31:0] = 32'h00000F00;
    tick();
    check("mul_ready", pcpi_ready, 1);
    check("mul_wr",    pcpi_wr, 1);
    check("mul_rd",    pcpi_rd, 32'h00000F00);
    check("mul_drain_cpv", cp_valid, 2'b00);
    cp_idle();
    tick();
    check("mul_one_pulse", pcpi_ready, 0);
    check("mul_rd_hold",   pcpi_rd, 32'h00000F00);
    release_req();

    // Both claim in the same cycle: cp0 wins, cp1's response ignored
    pcpi_valid = 1'b1; pcpi_insn = 32'h02C5C533;
    tick();
    cp_wait = 2'b11;
    tick();
    check("dual_busy_cpv", cp_valid, 2'b01);
    cp_wait = 2'b01; cp_ready = 2'b10; cp_wr = 2'b10; cp_rd[63:32] = 32'hDEADBEEF;
    #1;
    check("dual_owner_wait", pcpi_wait, 1);
    tick();
    check("dual_ignore_cp1", pcpi_ready, 0);
    cp_idle();
    cp_ready = 2'b01; cp_wr = 2'b01; cp_rd[31:0] = 32'h0000ABCD;
    tick();
    check("dual_ready", pcpi_ready, 1);
    check("dual_rd",    pcpi_rd, 32'h0000ABCD);
    release_req();

    // No claimant: trap exactly 16 cycles after CLAIM entry
    pcpi_valid = 1'b1; pcpi_insn = 32'hFFFFFFFF;
    tick();
    for (int i = 1; i < 16; i++) begin
      tick();
      check("to_early_trap", trap, 0);
    end
    tick();
    check("to_trap",    trap, 1);
    check("to_noready", pcpi_ready, 0);
    tick();
    check("to_trap_pulse", trap, 0);
    check("to_drain_cpv",  cp_valid, 2'b00);
    release_req();
    pcpi_valid = 1'b1;
    #1;
    check("to_back_idle", cp_valid, 2'b00);
    tick();
    check("to_reclaim_cpv", cp_valid, 2'b11);
    // abort: core drops valid while in CLAIM
    pcpi_valid = 1'b0;
    tick();
    check("abort_trap", trap, 0);
    pcpi_valid = 1'b1;
    #1;
    check("abort_idle_cpv", cp_valid, 2'b00);

    // cp1 claims via wait and hangs: trap after 128 BUSY cycles
    tick();
    cp_wait = 2'b10;
    tick();
    check("hang_busy_cpv", cp_valid, 2'b10);
    check("hang_wait", pcpi_wait, 1);
    for (int i = 1; i < 128; i++) begin
      tick();
      if (trap !== 1'b0 || pcpi_ready !== 1'b0) check("hang_early", {trap, pcpi_ready}, 0);
    end
    tick();
    check("hang_trap",    trap, 1);
    check("hang_noready", pcpi_ready, 0);
    release_req();

    // Single-cycle cp1
    pcpi_valid = 1'b1; pcpi_insn = 32'h02D6C5B3;
    tick();
    cp_ready = 2'b10; cp_wr = 2'b10; cp_rd[63:32] = 32'h12345678;
    tick();
    check("fast_ready", pcpi_ready, 1);
    check("fast_wr",    pcpi_wr, 1);
    check("fast_rd",    pcpi_rd, 32'h12345678);
    check("fast_notrap", trap, 0);
    release_req();

    // Reset in BUSY coinciding with owner ready
    pcpi_valid = 1'b1;
    tick();
    cp_wait = 2'b01;
    tick();
    cp_wait = 2'b00; cp_ready = 2'b01; cp_wr = 2'b01; cp_rd[31:0] = 32'h55555555;
    reset = 1'b1;
    tick();
    check("rstb_ready", pcpi_ready, 0);
    check("rstb_trap",  trap, 0);
    check("rstb_wr",    pcpi_wr, 0);
    check("rstb_rd",    pcpi_rd, 0);
    check("rstb_cpv",   cp_valid, 2'b00);
    reset = 1'b0;
    cp_idle();
    tick();
    check("rstb_reclaim_cpv", cp_valid, 2'b11);
    check("rstb_no_late", pcpi_ready, 0);
    release_req();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
